piece_row_ctrl: RTL and testbench
=================================

Name:
piece_row_ctrl

Overview:
- Sequencer that owns the write port of the 5-bit falling-piece row register (a reg5 instance): drives its data and write enable.
- Arbitrates three row-advance requesters: gravity timer (internal), soft drop, hard drop.
- Handles spawn, falling, lock delay and the lock pulse that hands off to board-merge logic.
- Sits between the input/timing logic and the row reg5; the board collision checker feeds it collide_below.

Parameters:
ROW_W, 5, width of row value (matches reg5)
SPAWN_ROW, 0, row written on spawn
BOTTOM_ROW, 19, last legal row (must be < 2^ROW_W - 1)
TICK_DIV, 50, clock cycles per gravity step (>= 2)
LOCK_CYC, 8, lock-delay cycles once piece rests (>= 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; low forces all state to reset values immediately
start  input  1  spawn a new piece; honoured only in IDLE
soft_drop  input  1  level; request one-row advance, rate-limited to one per cycle
hard_drop  input  1  pulse or level; latches drop-to-floor mode for current piece
collide_below  input  1  combinational from board: piece cannot occupy row_q+1
row_q  input  ROW_W  current value of the row reg5
row_we  output  1  write enable to row reg5 (its inEnabled)
row_d  output  ROW_W  data to row reg5
active  output  1  piece in play (FALL or LOCKWAIT)
locked  output  1  one-cycle pulse: piece locked at row_q

Behaviour:
- Reset (reset low): state=IDLE, tick_cnt=0, lock_cnt=0, hd_flag=0, locked=0. Combinationally row_we=0, row_d=0, active=0.
- row_we/row_d are decoded combinationally from registered state plus inputs. reg5 captures at the same edge, so row_q reflects a write on the next cycle.
- locked is registered. active is decoded from state.
- States and transitions:
  - IDLE: start=1 -> SPAWN. Other inputs ignored; hd_flag held 0.
  - SPAWN (1 cycle): row_we=1, row_d=SPAWN_ROW. Clears tick_cnt and hd_flag -> FALL.
  - FALL:
    - hard_drop=1 in FALL or LOCKWAIT sets hd_flag.
    - tick_cnt increments each cycle and wraps TICK_DIV-1 -> 0; tick fires on the wrap.
    - step = hd_flag|hard_drop (every cycle), else soft_drop, else tick. Priority: hard > soft > tick.
    - A soft or hard step clears tick_cnt to 0.
    - On step with collide_below=0 and row_q < BOTTOM_ROW: row_we=1, row_d=row_q+1, stay in FALL.
    - On step with collide_below=1 or row_q >= BOTTOM_ROW: no write, -> LOCKWAIT with lock_cnt=0.
  - LOCKWAIT:
    - active=1. lock_cnt increments.
    - If collide_below=0 and row_q < BOTTOM_ROW (piece shifted off support): -> FALL, lock_cnt=0, tick_cnt=0.
    - Else if hd_flag=1: -> DONE immediately.
    - Else if lock_cnt == LOCK_CYC-1: -> DONE.
    - soft_drop is ignored. No writes occur.
  - DONE (1 cycle): locked=1 on the following cycle as a registered pulse, active=0 -> IDLE. start in DONE is ignored.
- Arithmetic: row_q+1 is computed at ROW_W bits. With BOTTOM_ROW < 2^ROW_W-1 it never wraps. row_q > BOTTOM_ROW is treated as floor.
- Simultaneous events: hard_drop+soft_drop+tick in the same cycle produces exactly one step (one row).
- collide_below is sampled only in the step cycle while in FALL.
- Reset mid-operation: row_we drops asynchronously. A pending step is discarded. No locked pulse.

Test Plan:
- Bench overrides TICK_DIV=4, LOCK_CYC=3. Reset low, then high; start=1 for 1 cycle -> SPAWN cycle with row_we=1, row_d=0. Then row_we pulses every 4th cycle with row_d=1,2,3. active=1.
- Gravity to floor: collide_below=0 throughout -> writes through row_d=19. The next tick gives no write; LOCKWAIT lasts 3 cycles, then locked=1 for exactly 1 cycle, active=0.
- Soft drop held from row 5 -> row_we=1 every cycle, row_d=6,7,8. Release -> next gravity write 4 cycles later.
- Hard drop pulse at row 3, collide_below rises when row_q=10 -> writes 4..10 on consecutive cycles, no lock delay, locked pulse 2 cycles after the collision sample.
- LOCKWAIT escape: resting at row 12 with collide_below=1, collide_below falls on lock_cnt=1 -> returns to FALL. Next tick writes row_d=13. No locked pulse.
- Reset asserted in FALL while soft_drop=1 -> row_we=0 in the same cycle, state IDLE. start is required before any further write.

Source files
------------

// File: rtl/piece_row_ctrl_if.sv
// Signal bundle between the falling-piece row sequencer and its neighbours:
// row-advance requests, the board collision flag and the row reg5 write port.
interface piece_row_ctrl_if #(
  parameter int ROW_W = 5
);
  logic             start;
  logic             soft_drop;
  logic             hard_drop;
  logic             collide_below;
  logic [ROW_W-1:0] row_q;
  logic             row_we;
  logic [ROW_W-1:0] row_d;
  logic             active;
  logic             locked;

  modport master (
    output start, soft_drop, hard_drop, collide_below, row_q,
    input  row_we, row_d, active, locked
  );

  modport slave (
    input  start, soft_drop, hard_drop, collide_below, row_q,
    output row_we, row_d, active, locked
  );
endinterface

// File: rtl/piece_row_ctrl.sv
// Falling-piece row sequencer: owns the row reg5 write port, arbitrates
// gravity / soft drop / hard drop, and runs spawn, lock delay and lock hand-off.
module piece_row_ctrl #(
  parameter int ROW_W      = 5,
  parameter int SPAWN_ROW  = 0,
  parameter int BOTTOM_ROW = 19,
  parameter int TICK_DIV   = 50,
  parameter int LOCK_CYC   = 8
) (
  input  logic            clk,
  input  logic            reset,
  piece_row_ctrl_if.slave bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LW = $clog2(LOCK_CYC + 1);

  localparam logic [ROW_W-1:0] SPAWN_R   = ROW_W'(SPAWN_ROW);
  localparam logic [ROW_W-1:0] BOTTOM_R  = ROW_W'(BOTTOM_ROW);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [LW-1:0]    LOCK_LAST = LW'(LOCK_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    FALL,
    LOCKWAIT,
    DONE
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   tick_cnt, tick_n;
  logic [LW-1:0]   lock_cnt, lock_n;
  logic            hd_flag, hd_n;
  logic            locked, locked_n;
  logic            row_we;
  logic [ROW_W-1:0] row_d;

  logic can_move;
  logic step;

  // A row below is free only when the board agrees and we are above the floor;
  // anything at or past BOTTOM_ROW counts as resting on the floor.
  assign can_move = !bus.collide_below && (bus.row_q < BOTTOM_R);
  assign step     = hd_flag || bus.hard_drop || bus.soft_drop || (tick_cnt == TICK_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      lock_cnt <= '0;
      hd_flag  <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      lock_cnt <= lock_n;
      hd_flag  <= hd_n;
      locked   <= locked_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_n  = state;
    tick_n   = tick_cnt;
    lock_n   = lock_cnt;
    hd_n     = hd_flag;
    locked_n = 1'b0;
    row_we   = 1'b0;
    row_d    = '0;

    unique case (state)
      IDLE: begin
        hd_n = 1'b0;
        if (bus.start) state_n = SPAWN;
      end

      SPAWN: begin
        row_we  = 1'b1;
        row_d   = SPAWN_R;
        tick_n  = '0;
        hd_n    = 1'b0;
        state_n = FALL;
      end

      FALL: begin
        if (bus.hard_drop) hd_n = 1'b1;
        if (step) begin
          // Any step restarts the gravity period, so a tick never follows a drop immediately.
          tick_n = '0;
          if (can_move) begin
            row_we = 1'b1;
            row_d  = bus.row_q + ROW_W'(1);
          end else begin
            state_n = LOCKWAIT;
            lock_n  = '0;
          end
        end else begin
          tick_n = tick_cnt + TW'(1);
        end
      end

      LOCKWAIT: begin
        if (bus.hard_drop) hd_n = 1'b1;
        lock_n = lock_cnt + LW'(1);
        if (can_move) begin
          state_n = FALL;
          lock_n  = '0;
          tick_n  = '0;
        end else if (hd_flag || (lock_cnt == LOCK_LAST)) begin
          state_n  = DONE;
          locked_n = 1'b1;
        end
      end

      DONE: begin
        hd_n    = 1'b0;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.row_we = row_we;
  assign bus.row_d  = row_d;
  assign bus.active = (state == FALL) || (state == LOCKWAIT);
  assign bus.locked = locked;

endmodule

// File: tb/tb_piece_row_ctrl.sv
// Self-checking bench for piece_row_ctrl: vector table, directed corner-case
// sequences and randomized traffic scored against a behavioural piece model.
module tb_piece_row_ctrl;

  localparam int ROW_W      = 5;
  localparam int SPAWN_ROW  = 0;
  localparam int BOTTOM_ROW = 19;
  localparam int TICK_DIV   = 4;
  localparam int LOCK_CYC   = 3;

  logic clk;
  logic reset;
  logic [ROW_W-1:0] row_reg;

  piece_row_ctrl_if #(.ROW_W(ROW_W)) bus ();

  piece_row_ctrl #(
    .ROW_W     (ROW_W),
    .SPAWN_ROW (SPAWN_ROW),
    .BOTTOM_ROW(BOTTOM_ROW),
    .TICK_DIV  (TICK_DIV),
    .LOCK_CYC  (LOCK_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the row reg5 that the sequencer writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          row_reg <= '0;
    else if (bus.row_we) row_reg <= bus.row_d;
  end
  assign bus.row_q = row_reg;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural piece model: one flag per phase of a piece's life plus plain counters.
  bit m_spawn, m_fall, m_rest, m_done, m_hd;
  int m_grav, m_rest_age;
  bit e_we, e_active, e_locked, e_step, e_room;
  int e_d;

  task automatic model_reset();
    m_spawn = 0; m_fall = 0; m_rest = 0; m_done = 0; m_hd = 0;
    m_grav = 0; m_rest_age = 0;
  endtask

  task automatic model_eval(input bit sd, input bit hd, input bit cb, input int rq);
    e_room   = !cb && (rq < BOTTOM_ROW);
    e_step   = m_fall && (m_hd || hd || sd || (m_grav == TICK_DIV - 1));
    e_we     = m_spawn || (e_step && e_room);
    e_d      = m_spawn ? SPAWN_ROW : (e_we ? rq + 1 : 0);
    e_active = m_fall || m_rest;
    e_locked = m_done;
  endtask

  task automatic model_advance(input bit st, input bit hd);
    if (m_spawn) begin
      m_spawn = 0; m_fall = 1; m_grav = 0; m_hd = 0;
    end else if (m_fall) begin
      if (e_step) begin
        m_grav = 0;
        if (!e_room) begin m_fall = 0; m_rest = 1; m_rest_age = 0; end
      end else begin
        m_grav++;
      end
      if (hd) m_hd = 1;
    end else if (m_rest) begin
      if (e_room) begin
        m_rest = 0; m_fall = 1; m_grav = 0;
      end else if (m_hd || m_rest_age == LOCK_CYC - 1) begin
        m_rest = 0; m_done = 1;
      end else begin
        m_rest_age++;
      end
      if (hd) m_hd = 1;
    end else if (m_done) begin
      m_done = 0; m_hd = 0;
    end else if (st) begin
      m_spawn = 1;
    end
  endtask

  logic             o_we, o_active, o_locked;
  logic [ROW_W-1:0] o_d;

  // Called at a falling edge; drives one cycle of inputs, scores it, ends at the next falling edge.
  task automatic step_cycle(input bit st, input bit sd, input bit hd, input bit cb);
    bus.start = st; bus.soft_drop = sd; bus.hard_drop = hd; bus.collide_below = cb;
    #1;
    o_we = bus.row_we; o_d = bus.row_d; o_active = bus.active; o_locked = bus.locked;
    model_eval(sd, hd, cb, int'(bus.row_q));
    check("row_we", o_we, e_we);
    if (e_we) check("row_d", o_d, e_d);
    check("active", o_active, e_active);
    check("locked", o_locked, e_locked);
    model_advance(st, hd);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.start = 0; bus.soft_drop = 0; bus.hard_drop = 0; bus.collide_below = 0;
    #1;
    check("rst_row_we", bus.row_we, 0);
    check("rst_row_d", bus.row_d, 0);
    check("rst_active", bus.active, 0);
    check("rst_locked", bus.locked, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    bit st, sd, hd, cb;
    bit we;
    int d;
    bit act, lk;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit st, sd, hd, cb, input bit we, input int d, input bit act, lk);
    vec_t v;
    v.st = st; v.sd = sd; v.hd = hd; v.cb = cb; v.we = we; v.d = d; v.act = act; v.lk = lk;
    vt.push_back(v);
  endtask

  int since, last_d, coll_at, lock_at, want, wait_n;
  bit cb, seen_lock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    bus.start = 0; bus.soft_drop = 0; bus.hard_drop = 0; bus.collide_below = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Spawn, gravity every 4th cycle, a short soft drop, and start ignored while falling.
    add(1,0,0,0, 0,0,0,0);
    add(0,0,0,0, 1,0,0,0);
    add(0,0,0,0, 0,0,1,0); add(0,0,0,0, 0,0,1,0); add(0,0,0,0, 0,0,1,0);
    add(0,0,0,0, 1,1,1,0);
    add(0,0,0,0, 0,0,1,0); add(0,0,0,0, 0,0,1,0); add(0,0,0,0, 0,0,1,0);
    add(0,0,0,0, 1,2,1,0);
    add(0,0,0,0, 0,0,1,0); add(0,0,0,0, 0,0,1,0); add(0,0,0,0, 0,0,1,0);
    add(0,0,0,0, 1,3,1,0);
    add(0,1,0,0, 1,4,1,0);
    add(0,1,0,0, 1,5,1,0);
    add(0,0,0,0, 0,0,1,0); add(0,0,0,0, 0,0,1,0); add(0,0,0,0, 0,0,1,0);
    add(0,0,0,0, 1,6,1,0);
    add(1,0,0,0, 0,0,1,0);
    foreach (vt[i]) begin
      step_cycle(vt[i].st, vt[i].sd, vt[i].hd, vt[i].cb);
      check($sformatf("vec%0d_we", i), o_we, vt[i].we);
      if (vt[i].we) check($sformatf("vec%0d_d", i), o_d, vt[i].d);
      check($sformatf("vec%0d_active", i), o_active, vt[i].act);
      check($sformatf("vec%0d_locked", i), o_locked, vt[i].lk);
    end

    // Gravity to the floor: last write is row 19, then 4 falling + 3 lock-delay cycles.
    since = 0; last_d = -1;
    for (int i = 0; i < 300; i++) begin
      step_cycle(0, 0, 0, 0);
      if (o_we) begin last_d = int'(o_d); since = 0; end
      else if (o_active) since++;
      if (o_locked) break;
    end
    check("floor_last_row", last_d, BOTTOM_ROW);
    check("floor_rest_cycles", since, 4 + LOCK_CYC);
    step_cycle(0, 0, 0, 0);
    check("floor_lock_pulse_width", o_locked, 0);

    // Hard drop pulsed at row 3, board blocks below row 10.
    step_cycle(1, 0, 0, 0);
    for (wait_n = 0; wait_n < 100 && !(m_fall && bus.row_q == 3); wait_n++) step_cycle(0, 0, 0, 0);
    check("hd_reach_row3", wait_n < 100, 1);
    step_cycle(0, 0, 1, 0);
    check("hd_first_we", o_we, 1);
    check("hd_first_row", o_d, 4);
    want = 5; coll_at = -1; lock_at = -1;
    for (int i = 0; i < 40 && lock_at < 0; i++) begin
      cb = (bus.row_q == 10);
      step_cycle(0, 0, 0, cb);
      if (cb && coll_at < 0) coll_at = i;
      else if (coll_at < 0) begin
        check("hd_step_we", o_we, 1);
        check("hd_step_row", o_d, want);
        want++;
      end
      if (o_locked) lock_at = i;
    end
    check("hd_lock_delay", lock_at - coll_at, 2);

    // Soft drop held from row 5, then release; gravity resumes a full period later.
    step_cycle(1, 0, 0, 0);
    for (wait_n = 0; wait_n < 100 && !(m_fall && bus.row_q == 5); wait_n++) step_cycle(0, 0, 0, 0);
    check("sd_reach_row5", wait_n < 100, 1);
    for (int i = 0; i < 3; i++) begin
      step_cycle(0, 1, 0, 0);
      check("sd_held_we", o_we, 1);
      check("sd_held_row", o_d, 6 + i);
    end
    for (wait_n = 0; wait_n < 10; wait_n++) begin
      step_cycle(0, 0, 0, 0);
      if (o_we) break;
    end
    check("sd_release_gap", wait_n, TICK_DIV - 1);
    check("sd_release_row", o_d, 9);

    // Asynchronous reset mid-cycle while a soft-drop write is pending.
    bus.soft_drop = 1;
    #1;
    check("rst_mid_pre_we", bus.row_we, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_we", bus.row_we, 0);
    check("rst_mid_active", bus.active, 0);
    check("rst_mid_locked", bus.locked, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step_cycle(0, 1, 1, 0);
      check("rst_idle_no_write", o_we, 0);
    end

    // Lock-delay escape: rest on row 12, support vanishes at lock_cnt=1.
    step_cycle(1, 0, 0, 0);
    for (wait_n = 0; wait_n < 100 && !(m_fall && bus.row_q == 12); wait_n++) step_cycle(0, 0, 0, 0);
    check("esc_reach_row12", wait_n < 100, 1);
    for (wait_n = 0; wait_n < 10 && !m_rest; wait_n++) step_cycle(0, 0, 0, 1);
    check("esc_enter_rest", wait_n < 10, 1);
    step_cycle(0, 1, 0, 1);
    check("esc_rest_active", o_active, 1);
    check("esc_rest_no_write", o_we, 0);
    step_cycle(0, 0, 0, 0);
    check("esc_shift_no_write", o_we, 0);
    seen_lock = 0;
    for (wait_n = 0; wait_n < 10; wait_n++) begin
      step_cycle(0, 0, 0, 0);
      if (o_locked) seen_lock = 1;
      if (o_we) break;
    end
    check("esc_tick_gap", wait_n, TICK_DIV - 1);
    check("esc_tick_row", o_d, 13);
    check("esc_no_lock", seen_lock, 0);
    step_cycle(0, 0, 1, 0);
    for (wait_n = 0; wait_n < 40 && !o_locked; wait_n++) step_cycle(0, 0, 0, 0);
    check("esc_finish_lock", o_locked, 1);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
